// File: rtl/asm_pkg.sv
// ----------------------------------------------------------------------------
// asm_pkg
// Shared instruction-set definitions used by the fetch stage, decode and
// instruction_mem.
// Instruction layout: {opcode[31:25], rd[24:20], rs[19:15], imm[14:0]}.
// Contents:
//   OPC_W, REG_W, IMM_W - field widths
//   PC_W, IR_W          - default word-address and instruction widths
//   OPC_*               - opcode encodings
//   R0, NOP_WORD        - canonical no-op instruction word
//   fetch_state_e       - fetch FSM state encoding
// ----------------------------------------------------------------------------
package asm_pkg;

    localparam int OPC_W = 7;
    localparam int REG_W = 5;
    localparam int IMM_W = 15;
    localparam int PC_W  = 14;
    localparam int IR_W  = 32;

    localparam logic [OPC_W-1:0] OPC_NOP = 7'd0;
    localparam logic [OPC_W-1:0] OPC_JMP = 7'd1;
    localparam logic [OPC_W-1:0] OPC_ADI = 7'd2;
    localparam logic [OPC_W-1:0] OPC_ADD = 7'd3;
    localparam logic [OPC_W-1:0] OPC_MOV = 7'd4;
    localparam logic [OPC_W-1:0] OPC_LD  = 7'd5;
    localparam logic [OPC_W-1:0] OPC_ST  = 7'd6;
    localparam logic [OPC_W-1:0] OPC_BEQ = 7'd7;

    localparam logic [REG_W-1:0] R0 = 5'd0;

    localparam logic [IR_W-1:0] NOP_WORD = {OPC_NOP, R0, R0, 15'd0};

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// ----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC selection for the fetch stage.
// Priority: redirect > early-jump target > sequential increment > hold.
// All arithmetic wraps modulo 2^PC_W.
// Ports:
//   pc_q           in   PC_W   current fetch address
//   redirect_valid in   1      execute-stage redirect
//   redirect_pc    in   PC_W   redirect target
//   advance        in   1      fetch stage advances this cycle
//   jmp_hit        in   1      instruction being fetched is an early-taken JMP
//   jmp_imm        in   IMM_W  signed word offset of that JMP
//   next_pc        out  PC_W   value pc_q takes on the next clock
// ----------------------------------------------------------------------------
module fetch_next_pc
    import asm_pkg::*;
#(
    parameter int PC_W = asm_pkg::PC_W
) (
    input  logic [PC_W-1:0]  pc_q,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             advance,
    input  logic             jmp_hit,
    input  logic [IMM_W-1:0] jmp_imm,
    output logic [PC_W-1:0]  next_pc
);

    // Wide enough to hold either the PC or the sign-extended offset, so the
    // add below works whether PC_W is narrower or wider than the immediate.
    localparam int SUM_W = (PC_W > IMM_W) ? PC_W : IMM_W;

    logic signed [IMM_W-1:0] imm_s;
    logic [SUM_W-1:0]        imm_ext;
    logic [SUM_W-1:0]        pc_ext;
    logic [PC_W-1:0]         seq_pc;
    logic [PC_W-1:0]         jmp_pc;

    assign imm_s   = $signed(jmp_imm);
    assign imm_ext = SUM_W'(imm_s);   // sign-extends: imm_s is signed
    assign pc_ext  = SUM_W'(pc_q);
    // Truncating the sum gives the target modulo 2^PC_W.
    assign jmp_pc  = PC_W'(pc_ext + imm_ext);
    assign seq_pc  = pc_q + PC_W'(1);

    always_comb begin
        next_pc = pc_q;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (advance && jmp_hit) begin
            next_pc = jmp_pc;
        end else if (advance) begin
            next_pc = seq_pc;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC, drives the word address to instruction_mem
// (combinational read, IR returned in the same cycle) and captures the
// returned word into the IF/ID register.
//
// Optional feature macro: FETCH_EARLY_JMP_EN
//   defined   - a JMP seen in fetch is taken immediately (pc += sext(imm))
//               and consumed here; it never reaches decode.
//   undefined - JMP flows to decode like any other instruction.
//
// Ports:
//   clk            in   1      rising-edge clock
//   rst_n          in   1      asynchronous active-low reset
//   stall          in   1      hold PC and IF/ID
//   redirect_valid in   1      taken branch/jump from execute
//   redirect_pc    in   PC_W   redirect target
//   imem_pc        out  PC_W   address to instruction_mem (always pc_q)
//   imem_ir        in   IR_W   instruction word from instruction_mem
//   if_valid       out  1      IF/ID holds a real instruction
//   if_ir          out  IR_W   IF/ID instruction, NOP_WORD when invalid
//   if_pc          out  PC_W   address of if_ir
//   dbg_state      out  2      current fetch FSM state (fetch_state_e)
//
// IF/ID handshake: if_valid is the valid, !stall is the ready. Decode takes
// the IF/ID contents on a rising edge where if_valid=1 and stall=0; while
// stall=1 the contents are held unchanged. redirect_valid overrides stall
// and flushes IF/ID to NOP_WORD.
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import asm_pkg::*;
#(
    parameter int          PC_W             = asm_pkg::PC_W,
    parameter int          IR_W             = asm_pkg::IR_W,
    parameter int unsigned RESET_PC         = 0,
    parameter int unsigned REDIRECT_BUBBLES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_pc,
    input  logic [IR_W-1:0] imem_ir,
    output logic            if_valid,
    output logic [IR_W-1:0] if_ir,
    output logic [PC_W-1:0] if_pc,
    output logic [1:0]      dbg_state
);

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
    localparam logic [2:0]      BUB_INIT   = 3'(REDIRECT_BUBBLES);
    localparam logic [IR_W-1:0] NOP_IR     = IR_W'(NOP_WORD);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] next_pc;
    logic [2:0]      bubble_cnt;
    logic            advance;
    logic            jmp_hit;

    // The fetch stage moves forward only in S_RUN without stall or redirect.
    assign advance = (state_q == S_RUN) && !stall && !redirect_valid;

`ifdef FETCH_EARLY_JMP_EN
    assign jmp_hit = advance && (imem_ir[IR_W-1 -: OPC_W] == OPC_JMP);
`else
    assign jmp_hit = 1'b0;
`endif

    fetch_next_pc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .pc_q           (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .jmp_hit        (jmp_hit),
        .jmp_imm        (imem_ir[IMM_W-1:0]),
        .next_pc        (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC_V;
            bubble_cnt <= 3'd0;
            if_valid   <= 1'b0;
            if_ir      <= NOP_IR;
            if_pc      <= '0;
        end else begin
            pc_q <= next_pc;
            if (redirect_valid) begin
                // Flush IF/ID; the target is fetched once back in S_RUN.
                if_valid <= 1'b0;
                if_ir    <= NOP_IR;
                if (REDIRECT_BUBBLES > 0) begin
                    state_q    <= S_BUBBLE;
                    bubble_cnt <= BUB_INIT;
                end else begin
                    state_q    <= S_RUN;
                    bubble_cnt <= 3'd0;
                end
            end else begin
                case (state_q)
                    S_BOOT: begin
                        // pc_q stays at RESET_PC so the first fetch is not lost.
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
                        if (!stall) begin
                            if (jmp_hit) begin
                                if_valid <= 1'b0;
                                if_ir    <= NOP_IR;
                            end else begin
                                if_valid <= 1'b1;
                                if_ir    <= imem_ir;
                                if_pc    <= pc_q;
                            end
                        end
                    end
                    S_BUBBLE: begin
                        // Counts down regardless of stall.
                        if_valid <= 1'b0;
                        if_ir    <= NOP_IR;
                        if (bubble_cnt <= 3'd1) begin
                            bubble_cnt <= 3'd0;
                            state_q    <= S_RUN;
                        end else begin
                            bubble_cnt <= bubble_cnt - 3'd1;
                        end
                    end
                    default: begin
                        state_q <= S_BOOT;
                    end
                endcase
            end
        end
    end

    assign imem_pc   = pc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import asm_pkg::*;

  localparam int PC_W = 14;
  localparam int IR_W = 32;
  localparam int W    = PC_W + IR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            stall = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic [PC_W-1:0] imem_pc;
  logic [IR_W-1:0] imem_ir;
  logic            if_valid;
  logic [IR_W-1:0] if_ir;
  logic [PC_W-1:0] if_pc;
  logic [1:0]      dbg_state;

  logic [IR_W-1:0] mem [0:16383];
  logic [IR_W-1:0] jmp_word;

  assign imem_ir = mem[imem_pc];

  instr_fetch_unit #(
    .PC_W             (PC_W),
    .IR_W             (IR_W),
    .RESET_PC         (0),
    .REDIRECT_BUBBLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_ir        (imem_ir),
    .if_valid       (if_valid),
    .if_ir          (if_ir),
    .if_pc          (if_pc),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [IR_W-1:0] mw(input logic [PC_W-1:0] a);
    return {7'h50, 11'h000, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [PC_W-1:0] pc);
    exp_q.push_back({pc, mem[pc]});
  endtask

  // Decode consumes IF/ID at the coming edge when if_valid && !stall.
  always @(negedge clk) begin
    if (if_valid && !stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc=%0d ir=%0h expected nothing", if_pc, if_ir);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({if_pc, if_ir} !== e) begin
          failures++;
          $display("FAIL sb_item: got pc=%0d ir=%0h expected pc=%0d ir=%0h",
                   if_pc, if_ir, e[W-1:IR_W], e[IR_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [PC_W-1:0] target);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = mw(PC_W'(i));
    jmp_word = {OPC_JMP, R0, R0, 15'o77771};
    mem[28] = jmp_word;

    // Reset state
    tick();
    tick();
    check("rst_imem_pc", 32'(imem_pc), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_ir", if_ir, NOP_WORD);
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_BOOT));

    // Test 1/2: reset release, sequential fetch, stall at pc 5
    for (int i = 0; i <= 5; i++) push(PC_W'(i));
    rst_n = 1'b1;
    tick();
    check("boot_imem_pc", 32'(imem_pc), 32'd0);
    check("boot_if_valid", 32'(if_valid), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("seq_imem_pc", 32'(imem_pc), 32'(i));
      check("seq_if_pc", 32'(if_pc), 32'(i - 1));
      check("seq_if_valid", 32'(if_valid), 32'd1);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_imem_pc", 32'(imem_pc), 32'd5);
      check("stall_if_pc", 32'(if_pc), 32'd4);
      check("stall_if_ir", if_ir, mw(14'd4));
    end
    stall = 1'b0;
    tick();
    check("resume_if_pc5", 32'(if_pc), 32'd5);
    check("resume_imem_pc6", 32'(imem_pc), 32'd6);
    tick();
    check("resume_if_pc6", 32'(if_pc), 32'd6);

    // Test 3: redirect to 100 with stall in the same cycle, 2 bubbles
    push(14'd100);
    do_redirect(14'd100);
    check("redir_imem_pc", 32'(imem_pc), 32'd100);
    check("redir_if_valid0", 32'(if_valid), 32'd0);
    check("redir_if_ir_nop", if_ir, NOP_WORD);
    check("redir_state", 32'(dbg_state), 32'(S_BUBBLE));
    tick();
    check("redir_if_valid1", 32'(if_valid), 32'd0);
    tick();
    check("redir_if_valid2", 32'(if_valid), 32'd0);
    check("redir_hold_pc", 32'(imem_pc), 32'd100);
    tick();
    check("redir_if_valid3", 32'(if_valid), 32'd1);
    check("redir_if_pc", 32'(if_pc), 32'd100);
    check("redir_next_pc", 32'(imem_pc), 32'd101);
    tick();

    // Test 4: wrap from 16383 to 0
    push(14'd16383);
    push(14'd0);
    do_redirect(14'd16383);
    tick();
    tick();
    tick();
    check("wrap_if_pc", 32'(if_pc), 32'd16383);
    check("wrap_if_ir", if_ir, mw(14'd16383));
    check("wrap_imem_pc", 32'(imem_pc), 32'd0);
    tick();
    check("wrap_if_pc0", 32'(if_pc), 32'd0);
    check("wrap_imem_pc1", 32'(imem_pc), 32'd1);
    tick();

    // Test 5: JMP at 28 with offset -7
`ifdef FETCH_EARLY_JMP_EN
    push(14'd21);
`else
    push(14'd28);
    push(14'd29);
`endif
    do_redirect(14'd28);
    tick();
    tick();
    check("jmp_imem_pc28", 32'(imem_pc), 32'd28);
    tick();
`ifdef FETCH_EARLY_JMP_EN
    check("ejmp_imem_pc", 32'(imem_pc), 32'd21);
    check("ejmp_if_valid", 32'(if_valid), 32'd0);
    check("ejmp_if_ir", if_ir, NOP_WORD);
    tick();
    check("ejmp_if_pc", 32'(if_pc), 32'd21);
`else
    check("jmp_imem_pc", 32'(imem_pc), 32'd29);
    check("jmp_if_valid", 32'(if_valid), 32'd1);
    check("jmp_if_pc", 32'(if_pc), 32'd28);
    check("jmp_if_ir", if_ir, jmp_word);
    tick();
    check("jmp_if_pc29", 32'(if_pc), 32'd29);
`endif
    tick();

    // Test 6: asynchronous reset mid-bubble at pc 40
    do_redirect(14'd40);
    check("mid_bubble_pc", 32'(imem_pc), 32'd40);
    check("mid_bubble_state", 32'(dbg_state), 32'(S_BUBBLE));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_imem_pc", 32'(imem_pc), 32'd0);
    check("arst_if_valid", 32'(if_valid), 32'd0);
    check("arst_if_ir", if_ir, NOP_WORD);
    check("arst_if_pc", 32'(if_pc), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(S_BOOT));
    push(14'd0);
    push(14'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rb_imem_pc", 32'(imem_pc), 32'd0);
    check("rb_if_valid", 32'(if_valid), 32'd0);
    tick();
    check("rb_if_pc0", 32'(if_pc), 32'd0);
    check("rb_if_ir0", if_ir, mw(14'd0));
    tick();
    check("rb_if_pc1", 32'(if_pc), 32'd1);
    tick();
    check("rb_if_pc2", 32'(if_pc), 32'd2);
    stall = 1'b1;
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
